// File: rtl/rtc_seq_pkg.sv
// Shared constants and types for the RTC multiplexed-bus sequencer.
package rtc_seq_pkg;

    localparam int unsigned PHASE_CYC_DEF = 4;

    // Bus phase sequence; a transaction walks ADDR_SETUP..RECOVER in order
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_ADDR_SETUP = 3'd1;
    localparam logic [2:0] ST_ADDR_STB   = 3'd2;
    localparam logic [2:0] ST_ADDR_HOLD  = 3'd3;
    localparam logic [2:0] ST_DATA_SETUP = 3'd4;
    localparam logic [2:0] ST_DATA_STB   = 3'd5;
    localparam logic [2:0] ST_DATA_HOLD  = 3'd6;
    localparam logic [2:0] ST_RECOVER    = 3'd7;

    localparam logic       BUS_CS_IDLE  = 1'b1;
    localparam logic       BUS_STB_IDLE = 1'b1;
    localparam logic       BUS_SEL_IDLE = 1'b0;
    localparam logic       BUS_OE_IDLE  = 1'b0;
    localparam logic [7:0] BUS_AD_IDLE  = 8'h00;

    typedef struct packed {
        logic       is_rd;
        logic [7:0] addr;
        logic [7:0] wdata;
    } seq_req_t;

endpackage

// File: rtl/rtc_phase_timer.sv
// Per-phase down-counter: load restarts a phase, expire_c marks its last cycle.
module rtc_phase_timer
#(
    parameter int unsigned PHASE_CYC = 4
)
(
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    output logic expire_c
);

    localparam int unsigned CNT_W = $clog2(PHASE_CYC);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(PHASE_CYC - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expire_c = (cnt == '0);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Turns single-cycle micro read/write strobes into timed RTC multiplexed-bus transactions.
// Optional RTC_SEQ_QUEUE_EN adds a one-entry pending buffer for requests arriving while busy.
module rtc_bus_sequencer
    import rtc_seq_pkg::*;
#(
    parameter int unsigned PHASE_CYC = PHASE_CYC_DEF
)
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_wr,
    input  logic       req_rd,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    input  logic       err_clr,
    output logic       busy,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       err_sticky,
    output logic       rtc_cs_n,
    output logic       rtc_ad_sel,
    output logic       rtc_rd_n,
    output logic       rtc_wr_n,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in
);

    logic [2:0] state;
    logic [2:0] state_next;
    seq_req_t   cur;
    seq_req_t   cur_next;
    seq_req_t   in_req;
    logic       new_req;
    logic       drop;
    logic       err_set;
    logic       expire_c;
    logic       load;
    logic [7:0] cap;
    logic       cs_n_next;
    logic       sel_next;
    logic       rd_n_next;
    logic       wr_n_next;
    logic       oe_next;
    logic [7:0] ad_next;

`ifdef RTC_SEQ_QUEUE_EN
    seq_req_t   pend;
    seq_req_t   pend_next;
    logic       pend_valid;
    logic       pend_valid_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend       <= '0;
            pend_valid <= 1'b0;
        end else begin
            pend       <= pend_next;
            pend_valid <= pend_valid_next;
        end
    end
`endif

    assign load = (state_next != state);

    rtc_phase_timer #(.PHASE_CYC(PHASE_CYC)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load),
        .expire_c (expire_c)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cur   <= '0;
        end else begin
            state <= state_next;
            cur   <= cur_next;
        end
    end

    // Next state, request launch and drop detection; a write wins over a simultaneous read
    always_comb begin
        state_next   = state;
        cur_next     = cur;
        drop         = 1'b0;
        new_req      = req_wr | req_rd;
        in_req.is_rd = ~req_wr;
        in_req.addr  = req_addr;
        in_req.wdata = req_wdata;
`ifdef RTC_SEQ_QUEUE_EN
        pend_next       = pend;
        pend_valid_next = pend_valid;
`endif
        if (state == ST_IDLE) begin
            if (new_req) begin
                state_next = ST_ADDR_SETUP;
                cur_next   = in_req;
            end
        end else begin
            if (expire_c) begin
                state_next = (state == ST_RECOVER) ? ST_IDLE : state + 3'd1;
            end
`ifdef RTC_SEQ_QUEUE_EN
            // End of RECOVER chains straight into the next transaction so busy never dips
            if (state == ST_RECOVER && expire_c) begin
                if (pend_valid) begin
                    state_next      = ST_ADDR_SETUP;
                    cur_next        = pend;
                    pend_next       = in_req;
                    pend_valid_next = new_req;
                end else if (new_req) begin
                    state_next = ST_ADDR_SETUP;
                    cur_next   = in_req;
                end
            end else if (new_req) begin
                if (!pend_valid) begin
                    pend_next       = in_req;
                    pend_valid_next = 1'b1;
                end else begin
                    drop = 1'b1;
                end
            end
`else
            drop = new_req;
`endif
        end
        err_set = drop | (req_wr & req_rd);
    end

    // Bus levels for the state being entered, so pins change on the same edge as the state
    always_comb begin
        cs_n_next = BUS_CS_IDLE;
        sel_next  = BUS_SEL_IDLE;
        rd_n_next = BUS_STB_IDLE;
        wr_n_next = BUS_STB_IDLE;
        oe_next   = BUS_OE_IDLE;
        ad_next   = BUS_AD_IDLE;
        case (state_next)
            ST_ADDR_SETUP, ST_ADDR_STB, ST_ADDR_HOLD: begin
                cs_n_next = 1'b0;
                oe_next   = 1'b1;
                ad_next   = cur_next.addr;
                wr_n_next = (state_next != ST_ADDR_STB);
            end
            ST_DATA_SETUP, ST_DATA_STB, ST_DATA_HOLD: begin
                cs_n_next = 1'b0;
                sel_next  = 1'b1;
                oe_next   = ~cur_next.is_rd;
                ad_next   = cur_next.is_rd ? BUS_AD_IDLE : cur_next.wdata;
                if (state_next == ST_DATA_STB) begin
                    wr_n_next = cur_next.is_rd;
                    rd_n_next = ~cur_next.is_rd;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy       <= 1'b0;
            rd_data    <= 8'h00;
            rd_valid   <= 1'b0;
            err_sticky <= 1'b0;
            rtc_cs_n   <= BUS_CS_IDLE;
            rtc_ad_sel <= BUS_SEL_IDLE;
            rtc_rd_n   <= BUS_STB_IDLE;
            rtc_wr_n   <= BUS_STB_IDLE;
            ad_out     <= BUS_AD_IDLE;
            ad_oe      <= BUS_OE_IDLE;
            cap        <= 8'h00;
        end else begin
            busy       <= (state_next != ST_IDLE);
            rtc_cs_n   <= cs_n_next;
            rtc_ad_sel <= sel_next;
            rtc_rd_n   <= rd_n_next;
            rtc_wr_n   <= wr_n_next;
            ad_out     <= ad_next;
            ad_oe      <= oe_next;
            if (state == ST_DATA_STB && expire_c) begin
                cap <= ad_in;
            end
            rd_valid <= (state == ST_DATA_HOLD) && expire_c && cur.is_rd;
            if ((state == ST_DATA_HOLD) && expire_c && cur.is_rd) begin
                rd_data <= cap;
            end
            if (err_set) begin
                err_sticky <= 1'b1;
            end else if (err_clr) begin
                err_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Self-checking bench for rtc_bus_sequencer with a small RTC register model and read scoreboard.
module tb_rtc_bus_sequencer;

    localparam int PC = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req_wr = 1'b0;
    logic       req_rd = 1'b0;
    logic [7:0] req_addr = 8'h00;
    logic [7:0] req_wdata = 8'h00;
    logic       err_clr = 1'b0;
    logic       busy;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       err_sticky;
    logic       rtc_cs_n;
    logic       rtc_ad_sel;
    logic       rtc_rd_n;
    logic       rtc_wr_n;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic [7:0] ad_in;

    int chk = 0;
    int pass = 0;

    logic [7:0] exp_mem [256];
    logic [7:0] exp_q [$];

    logic [7:0] rtc_mem [256];
    bit         rtc_wrote [256];
    logic [7:0] rtc_addr = 8'h00;

    always #5 clk = ~clk;

    rtc_bus_sequencer #(.PHASE_CYC(PC)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_wr     (req_wr),
        .req_rd     (req_rd),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .err_clr    (err_clr),
        .busy       (busy),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .err_sticky (err_sticky),
        .rtc_cs_n   (rtc_cs_n),
        .rtc_ad_sel (rtc_ad_sel),
        .rtc_rd_n   (rtc_rd_n),
        .rtc_wr_n   (rtc_wr_n),
        .ad_out     (ad_out),
        .ad_oe      (ad_oe),
        .ad_in      (ad_in)
    );

    // RTC chip model: latches address on address-phase WR, stores on data-phase WR
    always @(negedge clk) begin
        if (!rtc_cs_n && !rtc_wr_n) begin
            if (!rtc_ad_sel) begin
                rtc_addr <= ad_out;
            end else begin
                rtc_mem[rtc_addr]   <= ad_out;
                rtc_wrote[rtc_addr] <= 1'b1;
            end
        end
    end

    assign ad_in = (!rtc_cs_n && !rtc_rd_n) ?
                   (rtc_wrote[rtc_addr] ? rtc_mem[rtc_addr] : (rtc_addr ^ 8'h15)) : 8'h00;

    task automatic issue(input logic wr, input logic rd, input logic [7:0] a, input logic [7:0] d);
        req_wr    = wr;
        req_rd    = rd;
        req_addr  = a;
        req_wdata = d;
        if (rd && !wr) exp_q.push_back(exp_mem[a]);
        if (wr) exp_mem[a] = d;
        @(negedge clk);
        req_wr = 1'b0;
        req_rd = 1'b0;
    endtask

    task automatic observe(output int busy_c, output int wr_a, output int wr_d, output int rd_c,
                           output int both, output int oe_dat, output int cs_hi, output int rv_c,
                           output logic [7:0] ad_a, output logic [7:0] ad_d, output logic [7:0] rv_d);
        busy_c = 0; wr_a = 0; wr_d = 0; rd_c = 0; both = 0; oe_dat = 0; cs_hi = 0; rv_c = 0;
        ad_a = 8'h00; ad_d = 8'h00; rv_d = 8'h00;
        for (int i = 0; i < 400; i++) begin
            if (!busy) break;
            busy_c++;
            if (!rtc_wr_n && !rtc_rd_n) both++;
            if (!rtc_wr_n && !rtc_ad_sel) begin wr_a++; ad_a = ad_out; end
            if (!rtc_wr_n && rtc_ad_sel) begin wr_d++; ad_d = ad_out; end
            if (!rtc_rd_n) rd_c++;
            if (rtc_ad_sel && ad_oe && !rtc_cs_n && !rtc_wr_n) oe_dat += 0;
            if (rtc_ad_sel && ad_oe) oe_dat++;
            if (rtc_cs_n) cs_hi++;
            if (rd_valid) begin rv_c++; rv_d = rd_data; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk++; if ({busy, rd_valid, err_sticky, rtc_ad_sel, ad_oe} !== 5'b0) $display("FAIL reset_lows got %b exp 00000", {busy, rd_valid, err_sticky, rtc_ad_sel, ad_oe}); else pass++;
        chk++; if ({rtc_cs_n, rtc_rd_n, rtc_wr_n} !== 3'b111) $display("FAIL reset_strobes got %b exp 111", {rtc_cs_n, rtc_rd_n, rtc_wr_n}); else pass++;
        chk++; if ({rd_data, ad_out} !== 16'h0000) $display("FAIL reset_data got %h exp 0000", {rd_data, ad_out}); else pass++;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        int bc, wa, wd, rc, bo, od, ch, rv;
        logic [7:0] aa, ad, rvd;
        issue(1'b1, 1'b0, 8'h21, 8'h45);
        observe(bc, wa, wd, rc, bo, od, ch, rv, aa, ad, rvd);
        chk++; if (bc !== 7 * PC) $display("FAIL wr_busy_cycles got %0d exp %0d", bc, 7 * PC); else pass++;
        chk++; if (wa !== PC || aa !== 8'h21) $display("FAIL wr_addr_phase got %0d/%h exp %0d/21", wa, aa, PC); else pass++;
        chk++; if (wd !== PC || ad !== 8'h45) $display("FAIL wr_data_phase got %0d/%h exp %0d/45", wd, ad, PC); else pass++;
        chk++; if (rc !== 0 || bo !== 0 || rv !== 0) $display("FAIL wr_no_read got rd=%0d both=%0d rv=%0d exp 0/0/0", rc, bo, rv); else pass++;
        chk++; if (ch !== PC) $display("FAIL wr_recover_cs got %0d exp %0d", ch, PC); else pass++;
    endtask

    task automatic test_read();
        int bc, wa, wd, rc, bo, od, ch, rv;
        logic [7:0] aa, ad, rvd, e;
        issue(1'b0, 1'b1, 8'h22, 8'h00);
        observe(bc, wa, wd, rc, bo, od, ch, rv, aa, ad, rvd);
        e = 8'hxx;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        chk++; if (rc !== PC || wd !== 0 || aa !== 8'h22) $display("FAIL rd_strobes got rd=%0d wrd=%0d a=%h exp %0d/0/22", rc, wd, aa, PC); else pass++;
        chk++; if (od !== 0) $display("FAIL rd_oe_data_phase got %0d exp 0", od); else pass++;
        chk++; if (rv !== 1 || rvd !== e) $display("FAIL rd_valid_data got %0d/%h exp 1/%h", rv, rvd, e); else pass++;
        chk++; if (rvd !== 8'h37) $display("FAIL rd_value_0x22 got %h exp 37", rvd); else pass++;
        repeat (5) @(negedge clk);
        chk++; if (rd_data !== 8'h37 || rd_valid !== 1'b0) $display("FAIL rd_hold got %h/%b exp 37/0", rd_data, rd_valid); else pass++;
        issue(1'b0, 1'b1, 8'h21, 8'h00);
        observe(bc, wa, wd, rc, bo, od, ch, rv, aa, ad, rvd);
        e = 8'hxx;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        chk++; if (rv !== 1 || rvd !== e) $display("FAIL rd_after_write got %0d/%h exp 1/%h", rv, rvd, e); else pass++;
    endtask

    task automatic test_conflict();
        int bc, wa, wd, rc, bo, od, ch, rv;
        logic [7:0] aa, ad, rvd;
        issue(1'b1, 1'b1, 8'h30, 8'h99);
        observe(bc, wa, wd, rc, bo, od, ch, rv, aa, ad, rvd);
        chk++; if (wd !== PC || ad !== 8'h99 || rc !== 0 || rv !== 0) $display("FAIL conflict_write_only got wd=%0d d=%h rd=%0d rv=%0d", wd, ad, rc, rv); else pass++;
        chk++; if (err_sticky !== 1'b1) $display("FAIL conflict_err got %b exp 1", err_sticky); else pass++;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk++; if (err_sticky !== 1'b0) $display("FAIL err_clr got %b exp 0", err_sticky); else pass++;
        err_clr = 1'b1;
        issue(1'b1, 1'b1, 8'h31, 8'h5C);
        err_clr = 1'b0;
        chk++; if (err_sticky !== 1'b1) $display("FAIL err_beats_clr got %b exp 1", err_sticky); else pass++;
        observe(bc, wa, wd, rc, bo, od, ch, rv, aa, ad, rvd);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic test_back_to_back_write();
        int bc, wd;
        logic [7:0] ad, rvd, e;
        int bc2, wa2, wd2, rc2, bo2, od2, ch2, rv2;
        logic [7:0] aa2, ad2;
        issue(1'b1, 1'b0, 8'h40, 8'h11);
        bc = 0; wd = 0; ad = 8'h00;
        for (int i = 0; i < 400; i++) begin
            if (!busy) break;
            bc++;
            if (!rtc_wr_n && rtc_ad_sel) begin wd++; ad = ad_out; end
            if (i == 4) begin
                req_wr = 1'b1; req_addr = 8'h41; req_wdata = 8'h22;
`ifdef RTC_SEQ_QUEUE_EN
                exp_mem[8'h41] = 8'h22;
`endif
            end
            if (i == 5) req_wr = 1'b0;
            @(negedge clk);
        end
`ifdef RTC_SEQ_QUEUE_EN
        chk++; if (bc !== 14 * PC) $display("FAIL b2b_busy got %0d exp %0d", bc, 14 * PC); else pass++;
        chk++; if (wd !== 2 * PC || ad !== 8'h22) $display("FAIL b2b_data got %0d/%h exp %0d/22", wd, ad, 2 * PC); else pass++;
        chk++; if (err_sticky !== 1'b0) $display("FAIL b2b_err got %b exp 0", err_sticky); else pass++;
`else
        chk++; if (bc !== 7 * PC) $display("FAIL b2b_busy got %0d exp %0d", bc, 7 * PC); else pass++;
        chk++; if (wd !== PC || ad !== 8'h11) $display("FAIL b2b_data got %0d/%h exp %0d/11", wd, ad, PC); else pass++;
        chk++; if (err_sticky !== 1'b1) $display("FAIL b2b_err got %b exp 1", err_sticky); else pass++;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
`endif
        issue(1'b0, 1'b1, 8'h41, 8'h00);
        observe(bc2, wa2, wd2, rc2, bo2, od2, ch2, rv2, aa2, ad2, rvd);
        e = 8'hxx;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        chk++; if (rv2 !== 1 || rvd !== e) $display("FAIL b2b_readback got %0d/%h exp 1/%h", rv2, rvd, e); else pass++;
    endtask

    task automatic test_reset_mid();
        int bc, wa, wd, rc, bo, od, ch, rv, found, rvseen;
        logic [7:0] aa, ad, rvd, e;
        issue(1'b0, 1'b1, 8'h50, 8'h00);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            if (!rtc_rd_n) begin found = 1; break; end
            @(negedge clk);
        end
        chk++; if (found !== 1) $display("FAIL rst_mid_reach_stb got %0d exp 1", found); else pass++;
        reset_n = 1'b0;
        #1;
        void'(exp_q.pop_back());
        chk++; if ({busy, rd_valid, ad_oe, rtc_ad_sel, rtc_cs_n, rtc_rd_n, rtc_wr_n} !== 7'b0000111) $display("FAIL rst_mid_outputs got %b exp 0000111", {busy, rd_valid, ad_oe, rtc_ad_sel, rtc_cs_n, rtc_rd_n, rtc_wr_n}); else pass++;
        chk++; if ({rd_data, ad_out} !== 16'h0000) $display("FAIL rst_mid_data got %h exp 0000", {rd_data, ad_out}); else pass++;
        rvseen = 0;
        repeat (3) begin
            @(negedge clk);
            if (rd_valid) rvseen++;
        end
        reset_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (rd_valid || busy) rvseen++;
        end
        chk++; if (rvseen !== 0) $display("FAIL rst_mid_no_pulse got %0d exp 0", rvseen); else pass++;
        issue(1'b0, 1'b1, 8'h51, 8'h00);
        observe(bc, wa, wd, rc, bo, od, ch, rv, aa, ad, rvd);
        e = 8'hxx;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        chk++; if (bc !== 7 * PC || rv !== 1 || rvd !== e) $display("FAIL rst_mid_recover got %0d/%0d/%h exp %0d/1/%h", bc, rv, rvd, 7 * PC, e); else pass++;
    endtask

    task automatic test_back_to_back_reads();
        int bc, wa, wd, rc, bo, od, ch, rv;
        logic [7:0] aa, ad, rvd, e;
        for (int k = 0; k < 4; k++) begin
            issue(1'b0, 1'b1, 8'h10 + 8'(k), 8'h00);
            observe(bc, wa, wd, rc, bo, od, ch, rv, aa, ad, rvd);
            e = 8'hxx;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            chk++; if (rv !== 1 || rvd !== e) $display("FAIL seq_read_%0d got %0d/%h exp 1/%h", k, rv, rvd, e); else pass++;
            chk++; if (ch < PC || bo !== 0) $display("FAIL seq_cs_gap_%0d got %0d/%0d exp >=%0d/0", k, ch, bo, PC); else pass++;
        end
        chk++; if (exp_q.size() !== 0) $display("FAIL scoreboard_drain got %0d exp 0", exp_q.size()); else pass++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) exp_mem[i] = 8'(i) ^ 8'h15;
        test_reset();
        test_write();
        test_read();
        test_conflict();
        test_back_to_back_write();
        test_reset_mid();
        test_back_to_back_reads();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
